// File: rtl/bus_addr_decoder_if.sv
// Bus bundle between the DLX memory stage, the address decoder and its slaves.
// The decoder connects through the slave modport; the pipeline side uses master.
interface bus_addr_decoder_if #(
    parameter int N_SLAVES = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
);
    logic                         m_req;
    logic [ADDR_W-1:0]            m_addr;
    logic                         m_we;
    logic [DATA_W-1:0]            m_wdata;
    logic                         m_busy;
    logic                         m_ack;
    logic                         m_err;
    logic [DATA_W-1:0]            m_rdata;
    logic [N_SLAVES-1:0]          s_cs;
    logic [ADDR_W-1:0]            s_addr;
    logic                         s_we;
    logic [DATA_W-1:0]            s_wdata;
    logic [N_SLAVES*DATA_W-1:0]   s_rdata;
    logic [N_SLAVES-1:0]          s_ack;

    modport master (
        output m_req, m_addr, m_we, m_wdata, s_rdata, s_ack,
        input  m_busy, m_ack, m_err, m_rdata, s_cs, s_addr, s_we, s_wdata
    );

    modport slave (
        input  m_req, m_addr, m_we, m_wdata, s_rdata, s_ack,
        output m_busy, m_ack, m_err, m_rdata, s_cs, s_addr, s_we, s_wdata
    );
endinterface

// File: rtl/bus_addr_decoder.sv
// Registered base/mask address decoder and single-outstanding bus bridge.
// Define BUS_DECODER_TIMEOUT_EN to build the ACCESS-state timeout counter.
module bus_addr_decoder #(
    parameter int                          N_SLAVES    = 2,
    parameter int                          ADDR_W      = 32,
    parameter int                          DATA_W      = 32,
    parameter logic [N_SLAVES*ADDR_W-1:0]  SLV_BASE    = {32'h1000_0000, 32'h0000_0001},
    parameter logic [N_SLAVES*ADDR_W-1:0]  SLV_MASK    = {32'hF000_0000, 32'hFFFF_FFFF},
    parameter int                          TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    bus_addr_decoder_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    if (N_SLAVES < 1 || N_SLAVES > 16 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("bus_addr_decoder: N_SLAVES must be 1..16 and TIMEOUT_CYC >= 2");
    end

    state_t               state_q, state_nxt;
    logic [N_SLAVES-1:0]  cs_q, cs_nxt;
    logic [ADDR_W-1:0]    addr_q, addr_nxt;
    logic                 we_q, we_nxt;
    logic [DATA_W-1:0]    wdata_q, wdata_nxt;
    logic [DATA_W-1:0]    rdata_q, rdata_nxt;
    logic                 ack_q, ack_nxt;
    logic                 err_q, err_nxt;

    logic [N_SLAVES-1:0]  hit_onehot;
    logic                 hit_any;
    logic                 sel_ack;
    logic [DATA_W-1:0]    rdata_sel;

`ifdef BUS_DECODER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0]     cnt_q, cnt_nxt;
`endif

    // Scan from the top slot down so the lowest matching index overrides.
    always_comb begin
        hit_onehot = '0;
        hit_any    = 1'b0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((bus.m_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
                (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W])) begin
                hit_onehot    = '0;
                hit_onehot[i] = 1'b1;
                hit_any       = 1'b1;
            end
        end
    end

    always_comb begin
        rdata_sel = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (cs_q[i]) begin
                rdata_sel = bus.s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Acks from slots that are not selected are masked off here.
    assign sel_ack = |(bus.s_ack & cs_q);

    always_comb begin
        state_nxt = state_q;
        cs_nxt    = cs_q;
        addr_nxt  = addr_q;
        we_nxt    = we_q;
        wdata_nxt = wdata_q;
        rdata_nxt = rdata_q;
        ack_nxt   = 1'b0;
        err_nxt   = 1'b0;
`ifdef BUS_DECODER_TIMEOUT_EN
        cnt_nxt   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.m_req) begin
                    addr_nxt  = bus.m_addr;
                    we_nxt    = bus.m_we;
                    wdata_nxt = bus.m_wdata;
                    if (hit_any) begin
                        state_nxt = ACCESS;
                        cs_nxt    = hit_onehot;
`ifdef BUS_DECODER_TIMEOUT_EN
                        cnt_nxt   = '0;
`endif
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (sel_ack) begin
                    state_nxt = IDLE;
                    cs_nxt    = '0;
                    ack_nxt   = 1'b1;
                    if (!we_q) begin
                        rdata_nxt = rdata_sel;
                    end
                end
`ifdef BUS_DECODER_TIMEOUT_EN
                // Count value TIMEOUT_CYC-1 here means this is the last allowed cycle.
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_nxt = IDLE;
                    cs_nxt    = '0;
                    err_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
                cs_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cs_q    <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef BUS_DECODER_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_nxt;
            cs_q    <= cs_nxt;
            addr_q  <= addr_nxt;
            we_q    <= we_nxt;
            wdata_q <= wdata_nxt;
            rdata_q <= rdata_nxt;
            ack_q   <= ack_nxt;
            err_q   <= err_nxt;
`ifdef BUS_DECODER_TIMEOUT_EN
            cnt_q   <= cnt_nxt;
`endif
        end
    end

    assign bus.m_busy  = (state_q == ACCESS);
    assign bus.m_ack   = ack_q;
    assign bus.m_err   = err_q;
    assign bus.m_rdata = rdata_q;
    assign bus.s_cs    = cs_q;
    assign bus.s_addr  = addr_q;
    assign bus.s_we    = we_q;
    assign bus.s_wdata = wdata_q;

endmodule

// File: tb/tb_bus_addr_decoder.sv
// Directed bench for bus_addr_decoder: vector table plus hand-written corner sequences.
// Timeout sequences are compiled in only when BUS_DECODER_TIMEOUT_EN is defined.
module tb_bus_addr_decoder;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bus_addr_decoder_if #(.N_SLAVES(2), .ADDR_W(32), .DATA_W(32)) bus ();

    bus_addr_decoder #(
        .N_SLAVES   (2),
        .ADDR_W     (32),
        .DATA_W     (32),
        .SLV_BASE   ({32'h1000_0000, 32'h0000_0001}),
        .SLV_MASK   ({32'hF000_0000, 32'hFFFF_FFFF}),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          ack_delay;
        logic [31:0] rdata;
        logic [1:0]  exp_cs;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic checkIdle(input string tag, input logic [31:0] exp_rdata);
        checkOutput({tag, "_cs"},    32'(bus.s_cs),   32'h0);
        checkOutput({tag, "_busy"},  32'(bus.m_busy), 32'h0);
        checkOutput({tag, "_ack"},   32'(bus.m_ack),  32'h0);
        checkOutput({tag, "_err"},   32'(bus.m_err),  32'h0);
        checkOutput({tag, "_rdata"}, bus.m_rdata,     exp_rdata);
    endtask

    // One full transaction from the vector table.
    task automatic applyStimulus(input int idx, input vec_t v);
        int slot;
        slot = v.exp_cs[1] ? 1 : 0;
        bus.m_req   = 1'b1;
        bus.m_addr  = v.addr;
        bus.m_we    = v.we;
        bus.m_wdata = v.wdata;
        step();
        bus.m_req = 1'b0;
        checkOutput($sformatf("v%0d_cs", idx),    32'(bus.s_cs),    32'(v.exp_cs));
        checkOutput($sformatf("v%0d_err", idx),   32'(bus.m_err),   32'(v.exp_err));
        checkOutput($sformatf("v%0d_busy", idx),  32'(bus.m_busy),  32'(v.exp_cs != 2'b00));
        checkOutput($sformatf("v%0d_saddr", idx), bus.s_addr,       v.addr);
        checkOutput($sformatf("v%0d_swe", idx),   32'(bus.s_we),    32'(v.we));
        checkOutput($sformatf("v%0d_swd", idx),   bus.s_wdata,      v.wdata);
        if (v.exp_cs != 2'b00) begin
            for (int c = 0; c < v.ack_delay; c++) begin
                step();
                checkOutput($sformatf("v%0d_hold%0d", idx, c), 32'(bus.s_cs), 32'(v.exp_cs));
                checkOutput($sformatf("v%0d_noack%0d", idx, c), 32'(bus.m_ack), 32'h0);
            end
            bus.s_rdata = {~v.rdata, ~v.rdata};
            bus.s_rdata[slot*32 +: 32] = v.rdata;
            bus.s_ack = v.exp_cs;
            step();
            bus.s_ack = 2'b00;
            checkOutput($sformatf("v%0d_ack", idx),    32'(bus.m_ack),  32'h1);
            checkOutput($sformatf("v%0d_ackerr", idx), 32'(bus.m_err),  32'h0);
            checkOutput($sformatf("v%0d_cs_off", idx), 32'(bus.s_cs),   32'h0);
            checkOutput($sformatf("v%0d_idle", idx),   32'(bus.m_busy), 32'h0);
            checkOutput($sformatf("v%0d_rdata", idx),  bus.m_rdata,     v.exp_rdata);
        end
        step();
        checkIdle($sformatf("v%0d_after", idx), v.exp_rdata);
    endtask

    initial begin
        reset       = 1'b1;
        bus.m_req   = 1'b0;
        bus.m_addr  = '0;
        bus.m_we    = 1'b0;
        bus.m_wdata = '0;
        bus.s_rdata = '0;
        bus.s_ack   = '0;

        vecs[0] = '{32'h1000_0040, 1'b0, 32'h0000_0000, 2, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'hDEAD_BEEF};
        vecs[1] = '{32'h0000_0001, 1'b1, 32'h0000_0005, 0, 32'h1234_5678, 2'b01, 1'b0, 32'hDEAD_BEEF};
        vecs[2] = '{32'h0000_0000, 1'b0, 32'h0000_0000, 0, 32'h0000_0000, 2'b00, 1'b1, 32'hDEAD_BEEF};
        vecs[3] = '{32'h1FFF_FFFC, 1'b0, 32'h0000_0000, 0, 32'h0BAD_F00D, 2'b10, 1'b0, 32'h0BAD_F00D};
        vecs[4] = '{32'h0000_0002, 1'b1, 32'h0000_0077, 0, 32'h0000_0000, 2'b00, 1'b1, 32'h0BAD_F00D};
        vecs[5] = '{32'h0000_0001, 1'b0, 32'h0000_0000, 1, 32'hA5A5_0001, 2'b01, 1'b0, 32'hA5A5_0001};
        vecs[6] = '{32'h2000_0000, 1'b0, 32'h0000_0000, 0, 32'h0000_0000, 2'b00, 1'b1, 32'hA5A5_0001};
        vecs[7] = '{32'h1000_0000, 1'b1, 32'hCAFE_0123, 3, 32'h5555_AAAA, 2'b10, 1'b0, 32'hA5A5_0001};

        step();
        step();
        checkIdle("rst", 32'h0);
        checkOutput("rst_saddr",  bus.s_addr,       32'h0);
        checkOutput("rst_swe",    32'(bus.s_we),    32'h0);
        checkOutput("rst_swdata", bus.s_wdata,      32'h0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // Stray ack from an unselected slot, then back-to-back request in the m_ack cycle.
        bus.m_req  = 1'b1;
        bus.m_addr = 32'h1000_0100;
        bus.m_we   = 1'b0;
        step();
        bus.m_req = 1'b0;
        checkOutput("b2b_cs1", 32'(bus.s_cs), 32'h2);
        bus.s_rdata = {32'h1111_2222, 32'h9999_9999};
        bus.s_ack   = 2'b01;
        step();
        checkOutput("stray_cs",   32'(bus.s_cs),   32'h2);
        checkOutput("stray_ack",  32'(bus.m_ack),  32'h0);
        checkOutput("stray_busy", 32'(bus.m_busy), 32'h1);
        bus.s_ack = 2'b10;
        step();
        bus.s_ack = 2'b00;
        checkOutput("b2b_ack1",   32'(bus.m_ack), 32'h1);
        checkOutput("b2b_rdata1", bus.m_rdata,    32'h1111_2222);
        bus.m_req  = 1'b1;
        bus.m_addr = 32'h0000_0001;
        bus.m_we   = 1'b0;
        step();
        bus.m_req = 1'b0;
        checkOutput("b2b_cs2",    32'(bus.s_cs),   32'h1);
        checkOutput("b2b_busy2",  32'(bus.m_busy), 32'h1);
        checkOutput("b2b_ackclr", 32'(bus.m_ack),  32'h0);
        checkOutput("b2b_saddr2", bus.s_addr,      32'h0000_0001);
        bus.s_rdata = {32'h7777_7777, 32'h3333_4444};
        bus.s_ack   = 2'b01;
        step();
        bus.s_ack = 2'b00;
        checkOutput("b2b_ack2",   32'(bus.m_ack), 32'h1);
        checkOutput("b2b_rdata2", bus.m_rdata,    32'h3333_4444);
        step();

`ifdef BUS_DECODER_TIMEOUT_EN
        // No ack: s_cs held for 16 ACCESS cycles, then m_err.
        bus.m_req  = 1'b1;
        bus.m_addr = 32'h1000_0200;
        bus.m_we   = 1'b0;
        step();
        bus.m_req = 1'b0;
        for (int c = 0; c < 15; c++) begin
            step();
            checkOutput($sformatf("tmo_hold%0d", c), 32'(bus.s_cs), 32'h2);
            checkOutput($sformatf("tmo_noerr%0d", c), 32'(bus.m_err), 32'h0);
        end
        step();
        checkOutput("tmo_err",  32'(bus.m_err),  32'h1);
        checkOutput("tmo_ack",  32'(bus.m_ack),  32'h0);
        checkOutput("tmo_cs",   32'(bus.s_cs),   32'h0);
        checkOutput("tmo_rd",   bus.m_rdata,     32'h3333_4444);
        step();
        checkIdle("tmo_after", 32'h3333_4444);

        // Ack on the limit cycle wins over the timeout.
        bus.m_req = 1'b1;
        step();
        bus.m_req = 1'b0;
        for (int c = 0; c < 15; c++) begin
            step();
        end
        bus.s_rdata = {32'h6060_6060, 32'h0};
        bus.s_ack   = 2'b10;
        step();
        bus.s_ack = 2'b00;
        checkOutput("tmo2_ack", 32'(bus.m_ack), 32'h1);
        checkOutput("tmo2_err", 32'(bus.m_err), 32'h0);
        checkOutput("tmo2_rd",  bus.m_rdata,    32'h6060_6060);
        step();
`endif

        // Reset two cycles into ACCESS abandons the transaction; a late ack is ignored.
        bus.m_req   = 1'b1;
        bus.m_addr  = 32'h1000_0300;
        bus.m_we    = 1'b1;
        bus.m_wdata = 32'hFACE_FACE;
        step();
        bus.m_req = 1'b0;
        step();
        checkOutput("rma_cs", 32'(bus.s_cs), 32'h2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkIdle("rma", 32'h0);
        checkOutput("rma_saddr",  bus.s_addr,    32'h0);
        checkOutput("rma_swe",    32'(bus.s_we), 32'h0);
        checkOutput("rma_swdata", bus.s_wdata,   32'h0);
        bus.s_ack = 2'b10;
        step();
        bus.s_ack = 2'b00;
        checkIdle("rma_late", 32'h0);
        step();
        checkIdle("rma_late2", 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_addr_decoder.md
Name: bus_addr_decoder

Overview:
Parametrised, registered address decoder and single-outstanding bus bridge between the DLX pipeline memory stage and N memory-mapped slaves (LED, RAM, future peripherals). It replaces fixed compare-to-constant chip selects with a base/mask region table. It also adds a request/acknowledge handshake, read-data return muxing, unmapped-address error reporting and an optional access timeout.

Parameters:
N_SLAVES, 2, number of slave channels (1..16)
ADDR_W, 32, address width
DATA_W, 32, data width
SLV_BASE, {32'h1000_0000, 32'h0000_0001}, packed N_SLAVES*ADDR_W; slot i at bits [i*ADDR_W +: ADDR_W] (slot 0 = LED, slot 1 = RAM)
SLV_MASK, {32'hF000_0000, 32'hFFFF_FFFF}, packed N_SLAVES*ADDR_W; compare mask per slot
TIMEOUT_CYC, 16, cycles in ACCESS before timeout error (>=2; used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
m_req  in  1  master request, sampled only while m_busy=0
m_addr  in  ADDR_W  request address
m_we  in  1  1=write, 0=read
m_wdata  in  DATA_W  write data
m_busy  out  1  transaction in flight
m_ack  out  1  one-cycle completion pulse
m_err  out  1  one-cycle error pulse (unmapped or timeout)
m_rdata  out  DATA_W  read data, valid from the m_ack cycle until the next read completes
s_cs  out  N_SLAVES  one-hot chip selects
s_addr  out  ADDR_W  captured address
s_we  out  1  captured write enable
s_wdata  out  DATA_W  captured write data
s_rdata  in  N_SLAVES*DATA_W  slave read data, slice i at [i*DATA_W +: DATA_W]
s_ack  in  N_SLAVES  slave completion strobes

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high.
- Reset values: state=IDLE; s_cs=0, m_busy=0, m_ack=0, m_err=0, m_rdata=0, s_addr=0, s_we=0, s_wdata=0, timeout counter=0.
- Hit rule: slot i hits when (m_addr & SLV_MASK[i]) == (SLV_BASE[i] & SLV_MASK[i]). With overlapping regions, the lowest index wins, so s_cs is always one-hot or zero.
- States: IDLE, ACCESS. m_busy = (state==ACCESS). All outputs are registered.
- IDLE, m_req=1 on edge T:
  - Capture m_addr, m_we and m_wdata into s_addr, s_we and s_wdata.
  - On a hit: enter ACCESS; s_cs[i]=1 from cycle T+1.
  - On a miss: stay in IDLE; m_err=1 in cycle T+1 only; no s_cs asserted.
- IDLE, m_req=0: no change; m_ack and m_err clear after one cycle.
- ACCESS: s_cs, s_addr, s_we and s_wdata are held stable. m_req is ignored (the master must not request while m_busy=1; such requests are dropped).
- Acknowledge: only s_ack of the selected slot is honoured; all other s_ack bits are ignored. Selected s_ack=1 at edge K:
  - next cycle: s_cs=0, state=IDLE, m_ack=1 for one cycle.
  - read: m_rdata = s_rdata slice of the selected slot, sampled at K.
  - write: m_rdata is unchanged.
- Minimum latency: request edge T -> s_cs at T+1 -> ack sampled at T+1 -> m_ack at T+2. A new m_req is accepted in the m_ack cycle, giving back-to-back throughput of one transaction per 2 cycles.
- Reset during ACCESS: the transaction is abandoned. s_cs drops at the reset edge, no m_ack or m_err is issued, and a late s_ack is ignored.
- m_ack and m_err are never high in the same cycle.

Optional Feature:
BUS_DECODER_TIMEOUT_EN
- Defined:
  - A counter clears on entering ACCESS and increments each ACCESS cycle without a selected ack.
  - When the count reaches TIMEOUT_CYC with no ack: s_cs=0, state=IDLE, m_err=1 for one cycle, m_rdata unchanged.
  - If the ack arrives in the same cycle the limit is reached, the ack wins (m_ack, not m_err).
- Undefined: no counter is built; ACCESS waits indefinitely for the ack.

Test Plan:
- Read of RAM: m_req with addr 0x1000_0040, we=0; s_ack[1] pulsed 3 cycles after s_cs[1] rises, s_rdata slot 1 = 0xDEAD_BEEF -> s_cs=2'b10 held for 3 cycles; m_ack one cycle later; m_rdata=0xDEAD_BEEF; m_err never asserted.
- Write to LED: addr 0x0000_0001, we=1, wdata 0x5; immediate s_ack[0] -> s_cs=2'b01 for 1 cycle; s_wdata=0x5; m_ack at T+2; m_rdata unchanged.
- Unmapped address: addr 0x0000_0000 -> no s_cs; m_err=1 exactly at T+1; m_busy stays 0.
- Stray ack and back-to-back: during a RAM access drive s_ack[0]=1 -> ignored; then s_ack[1]; m_req with a new address in the m_ack cycle -> accepted, s_cs reasserted the next cycle.
- Reset mid-access: assert reset 2 cycles into ACCESS, then pulse s_ack[1] -> all outputs at reset values; no m_ack or m_err.
- Timeout (BUS_DECODER_TIMEOUT_EN, TIMEOUT_CYC=16): no s_ack -> m_err after 16 ACCESS cycles, s_cs=0. A repeat run with the ack on cycle 16 -> m_ack, no m_err.
